main_mem_responder: RTL and testbench

//  Memory-side responder for the CPU's two memory initiators: instruction fetch and MEM stage.

---
 rtl/main_mem_responder_if.sv | 27 ++
 rtl/main_mem_responder.sv | 127 ++++++++++++
 tb/tb_main_mem_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_responder_if.sv
// Bus between the CPU's fetch/MEM-stage initiators and the main-memory responder.
// The master side drives requests; the slave side returns stalls and read beats.
interface main_mem_responder_if;
  logic        instr_req;
  logic [15:0] instr_addr;
  logic        data_req;
  logic        data_wr;
  logic [15:0] data_addr;
  logic [15:0] data_wr_data;
  logic        instr_stall;
  logic        data_stall;
  logic        resp_valid;
  logic        resp_port;
  logic [15:0] resp_addr;
  logic [15:0] resp_data;
  logic        busy;

  modport master (
    output instr_req, instr_addr, data_req, data_wr, data_addr, data_wr_data,
    input  instr_stall, data_stall, resp_valid, resp_port, resp_addr, resp_data, busy
  );

  modport slave (
    input  instr_req, instr_addr, data_req, data_wr, data_addr, data_wr_data,
    output instr_stall, data_stall, resp_valid, resp_port, resp_addr, resp_data, busy
  );
endinterface

// File: rtl/main_mem_responder.sv
// Fixed-latency main memory serving instruction fetch and MEM-stage requests:
// data-first arbitration, block-aligned read bursts, single-word write-through commits.
module main_mem_responder #(
  parameter int LATENCY   = 4,
  parameter int BURST_LEN = 8,
  parameter int MEM_AW    = 10
) (
  input  logic                clk,
  input  logic                rst,
  main_mem_responder_if.slave bus
);

  localparam int          CNT_MAX  = (LATENCY > BURST_LEN) ? LATENCY : BURST_LEN;
  localparam int          CW       = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [15:0] BLK_MASK = 16'(2 * BURST_LEN - 1);
  localparam int          DEPTH    = 1 << MEM_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    WACK  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic            port_r;
  logic            wr_r;
  logic [15:0]     base_r;
  logic            resp_valid_r;
  logic            busy_r;
  logic [15:0]     resp_addr_r;
  logic [15:0]     resp_data_r;
  logic [15:0]     mem_r [DEPTH];

  logic            accept_s;
  logic            wr_accept_s;
  logic            last_wait_s;
  logic            last_beat_s;
  logic            done_s;
  logic [15:0]     req_addr_s;
  logic [CW-1:0]   beat_idx_s;
  logic [15:0]     beat_addr_s;

  // Byte address to array word; Addr[0] and bits above MEM_AW alias.
  function automatic logic [MEM_AW-1:0] word_idx(input logic [15:0] addr);
    return addr[MEM_AW:1];
  endfunction

  // Acceptance, completion and next-beat address decode.
  always_comb begin
    accept_s    = (state_r == IDLE) && (bus.data_req || bus.instr_req);
    wr_accept_s = accept_s && bus.data_req && bus.data_wr;
    req_addr_s  = bus.data_req ? bus.data_addr : bus.instr_addr;
    last_wait_s = (cnt_r == CW'(LATENCY - 2));
    last_beat_s = (cnt_r == CW'(BURST_LEN - 1));
    done_s      = (state_r == WACK) || ((state_r == BURST) && last_beat_s);
    // Index of the beat presented in the following cycle
    beat_idx_s  = (state_r == BURST) ? (cnt_r + CW'(1)) : CW'(0);
    beat_addr_s = base_r + 16'({beat_idx_s, 1'b0});
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s)    state_s = WAIT;
               else             state_s = IDLE;
      WAIT:    if (last_wait_s) state_s = wr_r ? WACK : BURST;
               else             state_s = WAIT;
      BURST:   if (last_beat_s) state_s = IDLE;
               else             state_s = BURST;
      WACK:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, per-state counter and latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      port_r  <= 1'b0;
      wr_r    <= 1'b0;
      base_r  <= 16'h0000;
    end else begin
      state_r <= state_s;
      if ((state_s != state_r) || (state_r == IDLE)) cnt_r <= '0;
      else                                           cnt_r <= cnt_r + CW'(1);
      if (accept_s) begin
        port_r <= bus.data_req;
        wr_r   <= bus.data_req && bus.data_wr;
        base_r <= req_addr_s & ~BLK_MASK;
      end
    end
  end

  // Registered response outputs, computed from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      resp_addr_r  <= 16'h0000;
      resp_data_r  <= 16'h0000;
    end else begin
      resp_valid_r <= (state_s == BURST);
      busy_r       <= (state_s != IDLE);
      resp_addr_r  <= (state_s == BURST) ? beat_addr_s : 16'h0000;
      resp_data_r  <= (state_s == BURST) ? mem_r[word_idx(beat_addr_s)] : 16'h0000;
    end
  end

  // Array write on the accepting edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s && !rst) mem_r[word_idx(bus.data_addr)] <= bus.data_wr_data;
  end

  assign bus.instr_stall = bus.instr_req & ~rst & ~(~port_r & done_s);
  assign bus.data_stall  = bus.data_req  & ~rst & ~( port_r & done_s);
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_port   = port_r;
  assign bus.resp_addr   = resp_addr_r;
  assign bus.resp_data   = resp_data_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized and directed bench for main_mem_responder against a cycle-indexed
// transaction model (acceptance cycle, completion cycle, beat offsets).
module tb_main_mem_responder;
  localparam int LAT = 4;
  localparam int BL  = 8;

  logic clk = 1'b0;
  logic rst;
  main_mem_responder_if bus();

  main_mem_responder #(.LATENCY(LAT), .BURST_LEN(BL), .MEM_AW(10)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one transaction described by its start and completion cycles.
  logic [15:0] mem_m [0:1023];
  bit          op_on = 1'b0;
  bit          op_wr, owner;
  int          start_c, done_c;
  logic [15:0] base_m;
  logic        exp_is, exp_ds, exp_v, exp_b, exp_port;
  logic [15:0] exp_addr, exp_data;
  logic [15:0] vals [0:7];

  task automatic model_step();
    logic [15:0] a;
    exp_addr = 16'h0000;
    exp_data = 16'h0000;
    if (rst) begin
      op_on = 1'b0; owner = 1'b0;
      {exp_is, exp_ds, exp_v, exp_b, exp_port} = 5'b0;
      return;
    end
    if (op_on && cyc > done_c) op_on = 1'b0;
    if (!op_on && (bus.data_req || bus.instr_req)) begin
      op_on   = 1'b1;
      owner   = bus.data_req;
      op_wr   = bus.data_req && bus.data_wr;
      a       = bus.data_req ? bus.data_addr : bus.instr_addr;
      base_m  = a - (a % 16'(2 * BL));
      start_c = cyc;
      done_c  = cyc + LAT + (op_wr ? 0 : BL - 1);
      if (op_wr) mem_m[bus.data_addr[10:1]] = bus.data_wr_data;
    end
    exp_b    = op_on && cyc > start_c;
    exp_v    = op_on && !op_wr && cyc >= start_c + LAT;
    exp_port = owner;
    if (exp_v) begin
      exp_addr = base_m + 16'(2 * (cyc - start_c - LAT));
      exp_data = mem_m[exp_addr[10:1]];
    end
    exp_is = bus.instr_req && !(op_on && cyc == done_c && owner == 1'b0);
    exp_ds = bus.data_req  && !(op_on && cyc == done_c && owner == 1'b1);
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    bit done = 1'b0;
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = addr; bus.data_wr_data = data;
    for (int n = 0; n < 20 && !done; n++) begin
      sample();
      done = !bus.data_stall;
      advance();
    end
    bus.data_req = 1'b0; bus.data_wr = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL do_write_timeout addr=%h stall never dropped", addr);
    end
  endtask

  task automatic test_reset();
    sample();
    checks++;
    if ({bus.instr_stall, bus.data_stall, bus.resp_valid, bus.resp_port, bus.busy,
         bus.resp_addr, bus.resp_data} !== 37'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b p=%b b=%b a=%h d=%h required all 0",
               bus.resp_valid, bus.resp_port, bus.busy, bus.resp_addr, bus.resp_data);
    end
    advance();
    rst = 1'b0;
  endtask

  task automatic test_write();
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 16'h0010; bus.data_wr_data = 16'h1234;
    for (int k = 0; k < 6; k++) begin
      sample();
      checks++;
      if ({bus.instr_stall, bus.data_stall, bus.resp_valid, bus.busy} !== {exp_is, exp_ds, exp_v, exp_b}) begin
        errors++;
        $display("FAIL write_ctrl k=%0d got=%b required=%b", k,
                 {bus.instr_stall, bus.data_stall, bus.resp_valid, bus.busy}, {exp_is, exp_ds, exp_v, exp_b});
      end
      checks++;
      if ({bus.data_stall, bus.resp_valid} !== {(k < 4), 1'b0}) begin
        errors++;
        $display("FAIL write_stall k=%0d got stall=%b valid=%b required stall=%b valid=0",
                 k, bus.data_stall, bus.resp_valid, (k < 4));
      end
      advance();
      if (k == 4) begin bus.data_req = 1'b0; bus.data_wr = 1'b0; end
    end
    bus.data_req = 1'b1; bus.data_addr = 16'h0010;
    for (int k = 0; k < 13; k++) begin
      sample();
      if (k == 4) begin
        checks++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b1, 16'h1234}) begin
          errors++;
          $display("FAIL write_readback got valid=%b data=%h required 1/1234", bus.resp_valid, bus.resp_data);
        end
      end
      advance();
      if (k == 11) bus.data_req = 1'b0;
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 8; i++) begin
      vals[i] = 16'($urandom);
      do_write(16'h0010 + 16'(2 * i), vals[i]);
    end
    bus.instr_req = 1'b1; bus.instr_addr = 16'h0016;
    for (int k = 0; k < 13; k++) begin
      sample();
      checks++;
      if ({bus.instr_stall, bus.data_stall, bus.resp_valid, bus.busy} !== {exp_is, exp_ds, exp_v, exp_b}) begin
        errors++;
        $display("FAIL burst_ctrl k=%0d got=%b required=%b", k,
                 {bus.instr_stall, bus.data_stall, bus.resp_valid, bus.busy}, {exp_is, exp_ds, exp_v, exp_b});
      end
      if (k >= 4 && k <= 11) begin
        checks++;
        if ({bus.resp_valid, bus.resp_port, bus.resp_addr, bus.resp_data} !==
            {1'b1, 1'b0, 16'h0010 + 16'(2 * (k - 4)), vals[k - 4]}) begin
          errors++;
          $display("FAIL burst_beat k=%0d got v=%b p=%b a=%h d=%h required 1/0/%h/%h", k, bus.resp_valid,
                   bus.resp_port, bus.resp_addr, bus.resp_data, 16'h0010 + 16'(2 * (k - 4)), vals[k - 4]);
        end
      end
      if (k == 10 || k == 11) begin
        checks++;
        if (bus.instr_stall !== (k == 10)) begin
          errors++;
          $display("FAIL burst_stall k=%0d got=%b required=%b", k, bus.instr_stall, (k == 10));
        end
      end
      advance();
      if (k == 11) bus.instr_req = 1'b0;
    end
  endtask

  task automatic test_arbitration();
    bit v_c;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 16'h0010;
    bus.instr_req = 1'b1; bus.instr_addr = 16'h0018;
    for (int k = 0; k < 25; k++) begin
      sample();
      v_c = (k >= 4 && k <= 11) || (k >= 16 && k <= 23);
      checks++;
      if ({bus.instr_stall, bus.resp_valid} !== {(k <= 22), v_c}) begin
        errors++;
        $display("FAIL arb_timing k=%0d got istall=%b valid=%b required %b/%b",
                 k, bus.instr_stall, bus.resp_valid, (k <= 22), v_c);
      end
      if (v_c) begin
        checks++;
        if ({bus.resp_port, bus.resp_addr, bus.resp_data} !== {(k <= 11), exp_addr, exp_data}) begin
          errors++;
          $display("FAIL arb_beat k=%0d got p=%b a=%h d=%h required %b/%h/%h", k, bus.resp_port,
                   bus.resp_addr, bus.resp_data, (k <= 11), exp_addr, exp_data);
        end
      end
      advance();
      if (k == 11) bus.data_req = 1'b0;
      if (k == 23) bus.instr_req = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    bus.instr_req = 1'b1; bus.instr_addr = 16'h0010;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (k == 6) begin
        checks++;
        if ({bus.instr_stall, bus.data_stall, bus.resp_valid, bus.resp_port, bus.busy,
             bus.resp_addr, bus.resp_data} !== 37'b0) begin
          errors++;
          $display("FAIL rst_mid_outputs got v=%b b=%b a=%h d=%h required all 0",
                   bus.resp_valid, bus.busy, bus.resp_addr, bus.resp_data);
        end
      end
      if (k >= 7 && k <= 11) begin
        checks++;
        if ({bus.resp_valid, bus.busy} !== {(k == 11), (k > 7)} ||
            (k == 11 && bus.resp_addr !== 16'h0020)) begin
          errors++;
          $display("FAIL rst_relatency k=%0d got v=%b b=%b a=%h required %b/%b", k,
                   bus.resp_valid, bus.busy, bus.resp_addr, (k == 11), (k > 7));
        end
      end
      checks++;
      if ({bus.instr_stall, bus.data_stall, bus.resp_valid, bus.busy} !== {exp_is, exp_ds, exp_v, exp_b}) begin
        errors++;
        $display("FAIL rst_ctrl k=%0d got=%b required=%b", k,
                 {bus.instr_stall, bus.data_stall, bus.resp_valid, bus.busy}, {exp_is, exp_ds, exp_v, exp_b});
      end
      advance();
      if (k == 5) rst = 1'b1;
      if (k == 6) begin rst = 1'b0; bus.instr_addr = 16'h0020; end
      if (k == 18) bus.instr_req = 1'b0;
    end
  endtask

  task automatic test_alias();
    do_write(16'h0810, 16'hBEEF);
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 16'h0010;
    for (int k = 0; k < 13; k++) begin
      sample();
      if (k == 4) begin
        checks++;
        if ({bus.resp_valid, bus.resp_addr, bus.resp_data} !== {1'b1, 16'h0010, 16'hBEEF}) begin
          errors++;
          $display("FAIL alias_beat0 got v=%b a=%h d=%h required 1/0010/beef",
                   bus.resp_valid, bus.resp_addr, bus.resp_data);
        end
      end
      advance();
      if (k == 11) bus.data_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] x, y;
    x = 16'($urandom); y = 16'($urandom);
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 16'h0040; bus.data_wr_data = x;
    for (int k = 0; k < 11; k++) begin
      sample();
      checks++;
      if ({bus.data_stall, bus.busy} !== {(k <= 9 && k != 4 && k != 9), (k >= 1 && k <= 9 && k != 5)}) begin
        errors++;
        $display("FAIL b2b_ctrl k=%0d got stall=%b busy=%b required %b/%b", k, bus.data_stall, bus.busy,
                 (k <= 9 && k != 4 && k != 9), (k >= 1 && k <= 9 && k != 5));
      end
      advance();
      if (k == 1) bus.data_wr_data = 16'hDEAD;
      if (k == 4) begin bus.data_addr = 16'h0042; bus.data_wr_data = y; end
      if (k == 9) begin bus.data_req = 1'b0; bus.data_wr = 1'b0; end
    end
    bus.data_req = 1'b1; bus.data_addr = 16'h0040;
    for (int k = 0; k < 13; k++) begin
      sample();
      if (k == 4 || k == 5) begin
        checks++;
        if (bus.resp_data !== ((k == 4) ? x : y)) begin
          errors++;
          $display("FAIL b2b_readback k=%0d got=%h required=%h", k, bus.resp_data, (k == 4) ? x : y);
        end
      end
      advance();
      if (k == 11) bus.data_req = 1'b0;
    end
  endtask

  task automatic test_random();
    logic ni_req, nd_req, nd_wr;
    logic [15:0] ni_addr, nd_addr, nd_data;
    for (int k = 0; k < 600; k++) begin
      sample();
      checks++;
      if ({bus.instr_stall, bus.data_stall, bus.resp_valid, bus.busy} !== {exp_is, exp_ds, exp_v, exp_b}) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d got=%b required=%b", cyc,
                 {bus.instr_stall, bus.data_stall, bus.resp_valid, bus.busy}, {exp_is, exp_ds, exp_v, exp_b});
      end
      if (exp_b) begin
        checks++;
        if (bus.resp_port !== exp_port) begin
          errors++;
          $display("FAIL rand_port cyc=%0d got=%b required=%b", cyc, bus.resp_port, exp_port);
        end
      end
      if (exp_v && !$isunknown(exp_data)) begin
        checks++;
        if ({bus.resp_addr, bus.resp_data} !== {exp_addr, exp_data}) begin
          errors++;
          $display("FAIL rand_beat cyc=%0d got a=%h d=%h required a=%h d=%h", cyc,
                   bus.resp_addr, bus.resp_data, exp_addr, exp_data);
        end
      end
      ni_req = bus.instr_req; ni_addr = bus.instr_addr;
      nd_req = bus.data_req;  nd_addr = bus.data_addr; nd_wr = bus.data_wr; nd_data = bus.data_wr_data;
      if (bus.instr_req) begin
        if (!bus.instr_stall || $urandom_range(0, 63) == 0) ni_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        ni_req = 1'b1;
        ni_addr = 16'($urandom_range(0, 255)) | (16'($urandom_range(0, 31)) << 11);
      end
      if (bus.data_req) begin
        if (!bus.data_stall || $urandom_range(0, 63) == 0) nd_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        nd_req  = 1'b1;
        nd_wr   = ($urandom_range(0, 1) == 1);
        nd_addr = 16'($urandom_range(0, 255)) | (16'($urandom_range(0, 31)) << 11);
        nd_data = 16'($urandom);
      end
      advance();
      bus.instr_req = ni_req; bus.instr_addr = ni_addr;
      bus.data_req = nd_req; bus.data_addr = nd_addr; bus.data_wr = nd_wr; bus.data_wr_data = nd_data;
    end
    bus.instr_req = 1'b0; bus.data_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_req = 1'b0; bus.instr_addr = 16'h0000;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_addr = 16'h0000; bus.data_wr_data = 16'h0000;
    @(posedge clk);
    #1;
    test_reset();
    test_write();
    test_burst();
    test_arbitration();
    test_rst_mid();
    test_alias();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
